// File: rtl/controle_ula_mc_if.sv
// rtl/controle_ula_mc_if.sv - issue/decode and mul/div sequencer bundle for controle_ula_mc
interface controle_ula_mc_if #(
    parameter int CTRL_W = 5,
    parameter int CNT_W  = 5
);
    logic              valid_in;
    logic              flush;
    logic [3:0]        ALUOp;
    logic [5:0]        funct;
    logic              valid_out;
    logic [CTRL_W-1:0] ALUControl;
    logic              shamt;
    logic              JumpRegister;
    logic              illegal;
    logic              busy;
    logic              md_start;
    logic              md_step;
    logic [CNT_W-1:0]  md_count;
    logic              md_done;
    logic              hilo_we;

    modport master (
        output valid_in, flush, ALUOp, funct,
        input  valid_out, ALUControl, shamt, JumpRegister, illegal,
        input  busy, md_start, md_step, md_count, md_done, hilo_we
    );

    modport slave (
        input  valid_in, flush, ALUOp, funct,
        output valid_out, ALUControl, shamt, JumpRegister, illegal,
        output busy, md_start, md_step, md_count, md_done, hilo_we
    );
endinterface

// File: rtl/controle_ula_mc.sv
// rtl/controle_ula_mc.sv - registered ALU-control decode with iterative mul/div sequencer
module controle_ula_mc #(
    parameter int CTRL_W  = 5,
    parameter int MD_ITER = 32,
    parameter int CNT_W   = $clog2(MD_ITER)
) (
    input  logic clock,
    input  logic reset_n,
    controle_ula_mc_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(MD_ITER - 1);

    state_t     state;
    logic [4:0] dec_code;
    logic       dec_shamt;
    logic       dec_jr;
    logic       dec_illegal;
    logic       dec_md;
    logic       accept;

    always_comb begin
        dec_code    = 5'd0;
        dec_shamt   = 1'b0;
        dec_jr      = 1'b0;
        dec_illegal = 1'b0;
        if (bus.ALUOp == 4'b1111) begin
            case (bus.funct)
                6'b100000: dec_code = 5'b00000;
                6'b100010: dec_code = 5'b00001;
                6'b100100: dec_code = 5'b00101;
                6'b100101: dec_code = 5'b00110;
                6'b100110: dec_code = 5'b00111;
                6'b100111: dec_code = 5'b01111;
                6'b101010: dec_code = 5'b00011;
                6'b101011: dec_code = 5'b00100;
                6'b000000: begin dec_code = 5'b01001; dec_shamt = 1'b1; end
                6'b000010: begin dec_code = 5'b01010; dec_shamt = 1'b1; end
                6'b000011: begin dec_code = 5'b01011; dec_shamt = 1'b1; end
                6'b000100: dec_code = 5'b01001;
                6'b000110: dec_code = 5'b01010;
                6'b000111: dec_code = 5'b01011;
                6'b001000: begin dec_code = 5'b01100; dec_jr = 1'b1; end
                6'b011000: dec_code = 5'b10000;
                6'b011001: dec_code = 5'b10001;
                6'b011010: dec_code = 5'b10010;
                6'b011011: dec_code = 5'b10011;
                6'b010000: dec_code = 5'b10100;
                6'b010010: dec_code = 5'b10101;
                default:   dec_illegal = 1'b1;
            endcase
        end else if (bus.ALUOp <= 4'd8) begin
            dec_code = {1'b0, bus.ALUOp};
        end
    end

    // MULT/MULTU/DIV/DIVU occupy funct 0110xx
    assign dec_md = (bus.ALUOp == 4'b1111) && (bus.funct[5:2] == 4'b0110);
    assign accept = bus.valid_in && (state != RUN) && !bus.flush;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state            <= IDLE;
            bus.valid_out    <= 1'b0;
            bus.ALUControl   <= '0;
            bus.shamt        <= 1'b0;
            bus.JumpRegister <= 1'b0;
            bus.illegal      <= 1'b0;
            bus.busy         <= 1'b0;
            bus.md_start     <= 1'b0;
            bus.md_step      <= 1'b0;
            bus.md_count     <= '0;
            bus.md_done      <= 1'b0;
            bus.hilo_we      <= 1'b0;
        end else if (bus.flush) begin
            // ALUControl/shamt keep their last value: nothing was accepted
            state            <= IDLE;
            bus.valid_out    <= 1'b0;
            bus.JumpRegister <= 1'b0;
            bus.illegal      <= 1'b0;
            bus.busy         <= 1'b0;
            bus.md_start     <= 1'b0;
            bus.md_step      <= 1'b0;
            bus.md_count     <= '0;
            bus.md_done      <= 1'b0;
            bus.hilo_we      <= 1'b0;
        end else begin
            bus.valid_out    <= accept;
            bus.JumpRegister <= accept && dec_jr;
            bus.illegal      <= accept && dec_illegal;
            if (accept) begin
                bus.ALUControl <= CTRL_W'(dec_code);
                bus.shamt      <= dec_shamt;
            end
            bus.md_start <= 1'b0;
            bus.md_done  <= 1'b0;
            bus.hilo_we  <= 1'b0;
            case (state)
                RUN: begin
                    if (bus.md_count == LAST_ITER) begin
                        state        <= DONE;
                        bus.busy     <= 1'b0;
                        bus.md_step  <= 1'b0;
                        bus.md_done  <= 1'b1;
                        bus.hilo_we  <= 1'b1;
                    end else begin
                        bus.md_count <= bus.md_count + CNT_W'(1);
                        bus.md_step  <= 1'b1;
                    end
                end
                default: begin
                    // IDLE and DONE both accept; DONE chains straight into RUN
                    if (accept && dec_md) begin
                        state        <= RUN;
                        bus.busy     <= 1'b1;
                        bus.md_start <= 1'b1;
                        bus.md_step  <= 1'b1;
                        bus.md_count <= '0;
                    end else begin
                        state        <= IDLE;
                        bus.busy     <= 1'b0;
                        bus.md_step  <= 1'b0;
                        bus.md_count <= '0;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_controle_ula_mc.sv
// tb/tb_controle_ula_mc.sv - directed bench for controle_ula_mc, two parameter sets
module tb_controle_ula_mc;
    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    controle_ula_mc_if #(.CTRL_W(5), .CNT_W(5)) ia ();
    controle_ula_mc_if #(.CTRL_W(8), .CNT_W(2)) ib ();

    controle_ula_mc #(.CTRL_W(5), .MD_ITER(32)) dut_a (.clock(clock), .reset_n(reset_n), .bus(ia));
    controle_ula_mc #(.CTRL_W(8), .MD_ITER(4))  dut_b (.clock(clock), .reset_n(reset_n), .bus(ib));

    int n_vec  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: mul/div timeline tracked as "cycle the operation began"
    int        iters [2] = '{32, 4};
    int        rt    [64];
    int        cyc;
    int        m_begin [2];
    logic      m_valid [2];
    logic      m_jr    [2];
    logic      m_ill   [2];
    logic      m_sh    [2];
    int        m_code  [2];

    initial begin
        foreach (rt[j]) rt[j] = -1;
        rt[32] = 0;  rt[34] = 1;  rt[36] = 5;  rt[37] = 6;  rt[38] = 7;  rt[39] = 15;
        rt[42] = 3;  rt[43] = 4;  rt[0]  = 9;  rt[2]  = 10; rt[3]  = 11;
        rt[4]  = 9;  rt[6]  = 10; rt[7]  = 11; rt[8]  = 12;
        rt[24] = 16; rt[25] = 17; rt[26] = 18; rt[27] = 19; rt[16] = 20; rt[18] = 21;
    end

    function automatic int phase(input int i, input int c);
        return (m_begin[i] < 0) ? -1 : c - m_begin[i];
    endfunction

    function automatic logic in_run(input int i, input int c);
        int k = phase(i, c);
        return (k >= 0) && (k < iters[i]);
    endfunction

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cyc = 0;
            for (int i = 0; i < 2; i++) begin
                m_begin[i] = -1; m_valid[i] = 0; m_jr[i] = 0; m_ill[i] = 0;
                m_sh[i] = 0; m_code[i] = 0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                logic busy_prev;
                busy_prev = in_run(i, cyc);
                m_valid[i] = 0; m_jr[i] = 0; m_ill[i] = 0;
                if (ia.flush) begin
                    m_begin[i] = -1;
                end else if (ia.valid_in && !busy_prev) begin
                    int c;
                    c = (ia.ALUOp == 4'hF) ? rt[ia.funct] : ((ia.ALUOp <= 4'd8) ? int'(ia.ALUOp) : 0);
                    m_valid[i] = 1;
                    m_ill[i]   = (c < 0);
                    m_code[i]  = (c < 0) ? 0 : c;
                    m_jr[i]    = (ia.ALUOp == 4'hF) && (ia.funct == 6'd8);
                    m_sh[i]    = (ia.ALUOp == 4'hF) && (ia.funct == 6'd0 || ia.funct == 6'd2 || ia.funct == 6'd3);
                    if (c >= 16 && c <= 19) m_begin[i] = cyc + 1;
                end
            end
            cyc++;
        end
    end

    task automatic cmp(input int i, input string p, input logic vo, input int code, input logic sh,
                       input logic jr, input logic ill, input logic bsy, input logic st,
                       input logic stp, input int cnt, input logic dn, input logic hwe);
        int  k;
        logic run, done;
        k    = phase(i, cyc);
        run  = in_run(i, cyc);
        done = (k == iters[i]);
        chk({p, ".valid_out"}, vo, m_valid[i]);
        chk({p, ".ALUControl"}, code, m_code[i]);
        chk({p, ".shamt"}, sh, m_sh[i]);
        chk({p, ".JumpRegister"}, jr, m_jr[i]);
        chk({p, ".illegal"}, ill, m_ill[i]);
        chk({p, ".busy"}, bsy, run);
        chk({p, ".md_start"}, st, k == 0);
        chk({p, ".md_step"}, stp, run);
        chk({p, ".md_count"}, cnt, run ? k : (done ? iters[i] - 1 : 0));
        chk({p, ".md_done"}, dn, done);
        chk({p, ".hilo_we"}, hwe, done);
    endtask

    always @(negedge clock) begin
        cmp(0, "A", ia.valid_out, int'(ia.ALUControl), ia.shamt, ia.JumpRegister, ia.illegal,
            ia.busy, ia.md_start, ia.md_step, int'(ia.md_count), ia.md_done, ia.hilo_we);
        cmp(1, "B", ib.valid_out, int'(ib.ALUControl), ib.shamt, ib.JumpRegister, ib.illegal,
            ib.busy, ib.md_start, ib.md_step, int'(ib.md_count), ib.md_done, ib.hilo_we);
    end

    int jr_a = 0, hw_a = 0, busy_b = 0, max_b = 0;
    always @(negedge clock) begin
        if (ia.JumpRegister) jr_a++;
        if (ia.hilo_we) hw_a++;
        if (ib.busy) begin
            busy_b++;
            if (int'(ib.md_count) > max_b) max_b = int'(ib.md_count);
        end
    end

    task automatic drive(input logic v, input logic f, input logic [3:0] op, input logic [5:0] fn);
        ia.valid_in = v; ia.flush = f; ia.ALUOp = op; ia.funct = fn;
        ib.valid_in = v; ib.flush = f; ib.ALUOp = op; ib.funct = fn;
    endtask

    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    int rfun [18] = '{32, 34, 36, 37, 38, 42, 43, 0, 2, 3, 4, 6, 7, 8, 16, 18, 63, 39};

    initial begin
        int hw0, b0, gaps;
        logic found;
        drive(0, 0, 4'h0, 6'h00);
        repeat (3) tick();
        reset_n = 1'b1;

        drive(1, 0, 4'h0, 6'h00);
        tick();
        chk("first_valid_out", ia.valid_out, 1);
        chk("first_code", int'(ia.ALUControl), 0);

        for (int op = 0; op < 15; op++) begin
            drive(1, 0, 4'(op), 6'h2A);
            tick();
            if (op == 8) chk("lui_code", int'(ia.ALUControl), 8);
        end

        for (int n = 0; n < 18; n++) begin
            drive(1, 0, 4'hF, 6'(rfun[n]));
            tick();
            if (rfun[n] == 63) begin
                chk("illegal_flag", ia.illegal, 1);
                chk("illegal_code", int'(ia.ALUControl), 0);
            end
        end
        drive(0, 0, 4'h0, 6'h00);
        tick();
        chk("jr_pulses", jr_a, 1);
        chk("hold_code", int'(ia.ALUControl), 15);
        chk("idle_valid_out", ia.valid_out, 0);

        // MULT then MFLO held until the DONE exit edge
        hw0 = hw_a;
        drive(1, 0, 4'hF, 6'd24);
        tick();
        drive(1, 0, 4'hF, 6'd18);
        repeat (34) tick();
        chk("mult_hilo_pulses", hw_a - hw0, 1);
        chk("mflo_code", int'(ia.ALUControl), 21);
        drive(0, 0, 4'h0, 6'h00);
        tick();

        // DIV then DIVU back to back
        hw0 = hw_a; gaps = 0; found = 0;
        drive(1, 0, 4'hF, 6'd26);
        tick();
        drive(1, 0, 4'hF, 6'd27);
        for (int n = 0; n < 60 && !found; n++) begin
            tick();
            if (!ia.busy) gaps++;
            if (ia.valid_out) found = 1;
        end
        chk("b2b_second_accept", found, 1);
        chk("b2b_gap_cycles", gaps, 1);
        drive(0, 0, 4'h0, 6'h00);
        repeat (40) tick();
        chk("b2b_hilo_pulses", hw_a - hw0, 2);

        // flush in the middle of a MULT
        hw0 = hw_a; found = 0;
        drive(1, 0, 4'hF, 6'd24);
        tick();
        drive(0, 0, 4'h0, 6'h00);
        for (int n = 0; n < 40 && !found; n++) begin
            if (ia.busy && ia.md_count == 5'd10) found = 1;
            else tick();
        end
        chk("flush_reached_10", found, 1);
        drive(1, 1, 4'hF, 6'd32);
        tick();
        chk("flush_busy", ia.busy, 0);
        chk("flush_count", int'(ia.md_count), 0);
        chk("flush_valid_out", ia.valid_out, 0);
        drive(0, 0, 4'h0, 6'h00);
        repeat (40) tick();
        chk("flush_no_hilo", hw_a - hw0, 0);

        // short-iteration instance
        b0 = busy_b; max_b = 0;
        drive(1, 0, 4'hF, 6'd27);
        tick();
        chk("b_divu_code", int'(ib.ALUControl), 8'h13);
        drive(0, 0, 4'h0, 6'h00);
        repeat (8) tick();
        chk("b_busy_cycles", busy_b - b0, 4);
        chk("b_count_max", max_b, 3);
        repeat (32) tick();

        // asynchronous reset in the middle of a run
        drive(1, 0, 4'hF, 6'd24);
        tick();
        drive(0, 0, 4'h0, 6'h00);
        repeat (3) tick();
        hw0 = hw_a;
        @(posedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_code", int'(ia.ALUControl), 0);
        chk("arst_busy", ia.busy, 0);
        chk("arst_count", int'(ia.md_count), 0);
        chk("arst_b_code", int'(ib.ALUControl), 0);
        repeat (2) tick();
        reset_n = 1'b1;
        repeat (40) tick();
        chk("arst_no_hilo", hw_a - hw0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
